// File: rtl/conv_mac_seq_pkg.sv
// Shared types and defaults for the convolution MAC sequencer.
package conv_mac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_PIPE_LAT = 12;
  localparam int DEF_POST_LAT = 3;
  localparam int ACC_W        = 8;
  localparam int GRP_W        = 16;
  localparam int SCALE_W      = 16;

  function automatic logic cfg_bad(input logic [ACC_W-1:0] acc_num,
                                   input logic [GRP_W-1:0] num_out);
    return (acc_num == '0) || (num_out == '0);
  endfunction

endpackage

// File: rtl/conv_mac_seq_flag_delay_line.sv
// Fixed-depth single-bit shift register with synchronous clear; q_o is d_i delayed DEPTH cycles.
// pend_o flags any bit still travelling in a stage before the output stage.
module conv_mac_seq_flag_delay_line #(
  parameter int DEPTH = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o,
  output logic pend_o
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_sr <= '0;
        else if (clr_i) r_sr <= '0;
        else            r_sr <= d_i;
      end
      assign pend_o = 1'b0;
    end else begin : g_multi
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_sr <= '0;
        else if (clr_i) r_sr <= '0;
        else            r_sr <= {r_sr[DEPTH-2:0], d_i};
      end
      assign pend_o = |r_sr[DEPTH-2:0];
    end
  endgenerate

  assign q_o = r_sr[DEPTH-1];

endmodule

// File: rtl/conv_mac_seq.sv
// Sequences beat reads into the MAC array and tracks first/last flags down to accumulator restart and result valid.
// rd_en is combinational on rdy (0-cycle group start); a started group never stalls; abort clears everything next cycle.
module conv_mac_seq
  import conv_mac_seq_pkg::*;
#(
  parameter int MAC_OUT_NUM = 18,
  parameter int PIPE_LAT    = DEF_PIPE_LAT,
  parameter int POST_LAT    = DEF_POST_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic [ACC_W-1:0]       acc_num_i,
  input  logic [GRP_W-1:0]       num_out_i,
  input  logic [SCALE_W-1:0]     scale_i,
  input  logic                   abort_i,
  input  logic                   fm_grp_rdy_i,
  input  logic                   wt_grp_rdy_i,
  output logic                   rd_en_o,
  output logic                   mac_valid_o,
  output logic [MAC_OUT_NUM-1:0] adder_rst_o,
  output logic [ACC_W-1:0]       acc_num_o,
  output logic [SCALE_W-1:0]     scale_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc_num;
  logic [ACC_W-1:0]   r_beat;
  logic [GRP_W-1:0]   r_num_out;
  logic [GRP_W-1:0]   r_grp_cnt;
  logic [SCALE_W-1:0] r_scale;
  logic               r_in_grp;
  logic               r_done;
  logic               r_err;
  logic               r_mv_vld;
  logic               r_mv_first;
  logic               r_mv_last;

  logic w_rd_en;
  logic w_first_beat;
  logic w_last_beat;
  logic w_last_grp;
  logic w_first_q;
  logic w_first_pend;
  logic w_last_q;
  logic w_last_pend;
  logic w_drain_done;

  // Once a group has started it runs to its last beat whatever rdy does.
  assign w_rd_en      = (r_state == ST_ISSUE) && (r_in_grp || (fm_grp_rdy_i && wt_grp_rdy_i));
  assign w_first_beat = (r_beat == '0);
  assign w_last_beat  = (r_beat == (r_acc_num - 1'b1));
  assign w_last_grp   = (r_grp_cnt == (r_num_out - 1'b1));
  assign w_drain_done = !r_mv_vld && !w_first_pend && !w_last_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_acc_num <= '0;
      r_num_out <= '0;
      r_scale   <= '0;
      r_beat    <= '0;
      r_grp_cnt <= '0;
      r_in_grp  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort_i) begin
        r_state  <= ST_IDLE;
        r_beat   <= '0;
        r_grp_cnt <= '0;
        r_in_grp <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              if (cfg_bad(acc_num_i, num_out_i)) begin
                r_err <= 1'b1;
              end else begin
                r_acc_num <= acc_num_i;
                r_num_out <= num_out_i;
                r_scale   <= scale_i;
                r_beat    <= '0;
                r_grp_cnt <= '0;
                r_in_grp  <= 1'b0;
                r_state   <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            if (w_rd_en) begin
              if (w_last_beat) begin
                r_beat    <= '0;
                r_in_grp  <= 1'b0;
                r_grp_cnt <= r_grp_cnt + 1'b1;
                if (w_last_grp) r_state <= ST_DRAIN;
              end else begin
                r_beat   <= r_beat + 1'b1;
                r_in_grp <= 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            // The final result is on out_valid_o this cycle when nothing is left upstream of it.
            if (w_drain_done) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Buffer read latency is one cycle, so data reaches the MAC array one cycle after rd_en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mv_vld   <= 1'b0;
      r_mv_first <= 1'b0;
      r_mv_last  <= 1'b0;
    end else begin
      r_mv_vld   <= !abort_i && w_rd_en;
      r_mv_first <= !abort_i && w_rd_en && w_first_beat;
      r_mv_last  <= !abort_i && w_rd_en && w_last_beat;
    end
  end

  conv_mac_seq_flag_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_first_dl (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (abort_i),
    .d_i    (r_mv_first),
    .q_o    (w_first_q),
    .pend_o (w_first_pend)
  );

  conv_mac_seq_flag_delay_line #(
    .DEPTH (PIPE_LAT + POST_LAT)
  ) u_last_dl (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (abort_i),
    .d_i    (r_mv_last),
    .q_o    (w_last_q),
    .pend_o (w_last_pend)
  );

  assign rd_en_o     = w_rd_en;
  assign mac_valid_o = r_mv_vld;
  assign adder_rst_o = {MAC_OUT_NUM{w_first_q}};
  assign out_valid_o = w_last_q;
  assign acc_num_o   = r_acc_num;
  assign scale_o     = r_scale;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: doc/conv_mac_seq.md
CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 Parameters: MAC_OUT_NUM default 18 (adder-reset fan-out); PIPE_LAT default 12 (cycles from mac_valid_o to first product at accumulator); POST_LAT default 3 (accumulate+scale+clip cycles).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  job start pulse; sampled only in IDLE.
REQ-005 acc_num_i  in  8  beats per output group; latched at start.
REQ-006 num_out_i  in  16  output groups per job; latched at start.
REQ-007 scale_i  in  16  right-shift amount; latched at start.
REQ-008 abort_i  in  1  synchronous job cancel.
REQ-009 fm_grp_rdy_i / wt_grp_rdy_i  in  1 each  feature/weight buffer holds one full group (acc_num beats).
REQ-010 rd_en_o  out  1  pop one beat from both buffers; buffer read latency is 1 cycle.
REQ-011 mac_valid_o  out  1  data/weight valid to MAC array.
REQ-012 adder_rst_o  out  MAC_OUT_NUM  accumulator restart, all bits identical.
REQ-013 acc_num_o  out  8, scale_o  out  16  latched job config, stable while busy.
REQ-014 out_valid_o  out  1  clipped MAC result valid this cycle.
REQ-015 busy_o, done_o, err_o  out  1 each  job active / completion pulse / bad-config pulse.

Function
REQ-016 States IDLE, ISSUE, DRAIN; busy_o=1 in ISSUE and DRAIN.
REQ-017 IDLE: start_i with acc_num_i=0 or num_out_i=0 -> err_o one-cycle pulse, stay IDLE; otherwise latch config, clear counters, go ISSUE.
REQ-018 start_i while busy is ignored.
REQ-019 ISSUE: group begins only when fm_grp_rdy_i and wt_grp_rdy_i both 1 at a cycle boundary; then rd_en_o held 1 for exactly acc_num consecutive cycles regardless of rdy changes.
REQ-020 Next group may begin the cycle after the previous group's last beat (no bubble) if both rdy high.
REQ-021 mac_valid_o = rd_en_o delayed 1 cycle; first/last-beat flags travel with it.
REQ-022 adder_rst_o = first-beat flag delayed PIPE_LAT cycles after mac_valid_o.
REQ-023 out_valid_o = last-beat flag delayed PIPE_LAT+POST_LAT cycles after mac_valid_o; acc_num=1 sets first and last on same beat.
REQ-024 Group counter 16-bit; after num_out groups issued -> DRAIN; no further rd_en_o.
REQ-025 DRAIN: stay until every delay-line flag is empty and the final out_valid_o has fired; then done_o one-cycle pulse on the following cycle, go IDLE.
REQ-026 abort_i in any state: next cycle IDLE, rd_en_o/mac_valid_o/adder_rst_o/out_valid_o 0, delay lines cleared, no done_o; abort_i has priority over start_i.
REQ-027 Beat counter 8-bit, counts 0..acc_num-1 with no wrap beyond acc_num; acc_num=255 legal.

Reset
REQ-028 rstn low: state IDLE, all outputs 0, counters, config latches, delay lines 0; asynchronous assert, synchronous-safe deassert.
REQ-029 Reset mid-job: job lost, no done_o or out_valid_o after release.

Structure
REQ-030 Shared package: state encoding, PIPE_LAT/POST_LAT defaults, acc/group counter widths.
REQ-031 One sub-module natural: flag_delay_line (parameterised-depth shift register with synchronous clear), instantiated for first-beat and last-beat flags.

Verification (PIPE_LAT=12, POST_LAT=3, rdy held 1, start at cycle 0)
REQ-032 acc_num=4, num_out=1 -> rd_en 1..4, mac_valid 2..5, adder_rst 14, out_valid 20, done 21.
REQ-033 acc_num=1, num_out=3 -> rd_en 1..3, adder_rst 14..16, out_valid 17..19, done 20.
REQ-034 acc_num=2, num_out=2, wt_grp_rdy low cycles 3..7 -> rd_en 1..2 then 8..9; never a split group.
REQ-035 acc_num=0 or num_out=0 -> err_o pulse cycle 1, busy_o stays 0, no rd_en.
REQ-036 abort_i at cycle 3 of acc_num=4 job -> busy_o 0 at cycle 4, no adder_rst/out_valid/done afterwards.
REQ-037 rstn low at cycle 6 of REQ-032 job -> all outputs 0 immediately, nothing after release; new start then behaves as REQ-032.
